// File: rtl/datapath_pkg.sv
// ============================================================================
//  Module   : datapath_pkg
//  Brief    : Shared widths, ALU/opcode encodings and instruction field helpers
//             for the 8-bit datapath core.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package datapath_pkg;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;
    localparam int NREGS   = 8;
    localparam int RIDX_W  = 3;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_NOT = 3'd5,
        ALU_SHL = 3'd6,
        ALU_SHR = 3'd7
    } alu_op_e;

    localparam logic [3:0] OP_LDI    = 4'hF;
    localparam logic [3:0] OP_NOP_LO = 4'h8;
    localparam logic [3:0] OP_NOP_HI = 4'hE;

    function automatic logic [3:0] get_opcode(input logic [INSTR_W-1:0] ins);
        return ins[15:12];
    endfunction

    function automatic logic [RIDX_W-1:0] get_rd(input logic [INSTR_W-1:0] ins);
        return ins[11:9];
    endfunction

    function automatic logic [RIDX_W-1:0] get_rs1(input logic [INSTR_W-1:0] ins);
        return ins[8:6];
    endfunction

    function automatic logic [RIDX_W-1:0] get_rs2(input logic [INSTR_W-1:0] ins);
        return ins[5:3];
    endfunction

    function automatic logic [DATA_W-1:0] get_imm(input logic [INSTR_W-1:0] ins);
        return ins[7:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/datapath_core_alu.sv
// ============================================================================
//  Module   : dp_alu
//  Brief    : Combinational 8-bit ALU; carries/borrows are discarded and shift
//             amounts use only the low three bits of b.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dp_alu
    import datapath_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        case (alu_op_e'(op))
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_NOT: y = ~a;
            ALU_SHL: y = a << b[2:0];
            ALU_SHR: y = a >> b[2:0];
            default: y = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/datapath_core.sv
// ============================================================================
//  Module   : datapath_core
//  Brief    : Single-cycle 8-bit datapath: free-running PC, 8x8 register file
//             and ALU. Define DATAPATH_ZFLAG_EN to add the registered zflag.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module datapath_core
    import datapath_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [DATA_W-1:0]  debug_r0,
    output logic [DATA_W-1:0]  debug_r1,
`ifdef DATAPATH_ZFLAG_EN
    output logic [DATA_W-1:0]  debug_r2,
    output logic               zflag
`else
    output logic [DATA_W-1:0]  debug_r2
`endif
);

    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_regs [NREGS];

    logic [3:0]        w_opcode;
    logic [RIDX_W-1:0] w_rd;
    logic [DATA_W-1:0] w_rs1_val;
    logic [DATA_W-1:0] w_rs2_val;
    logic [DATA_W-1:0] w_alu_y;
    logic [DATA_W-1:0] w_wdata;
    logic              w_is_alu;
    logic              w_is_ldi;
    logic              w_we;

    assign w_opcode  = get_opcode(instr);
    assign w_rd      = get_rd(instr);
    assign w_rs1_val = r_regs[get_rs1(instr)];
    assign w_rs2_val = r_regs[get_rs2(instr)];

    // Opcodes 0x0-0x7 are ALU ops, 0xF is LDI, everything between is a NOP.
    assign w_is_alu = ~w_opcode[3];
    assign w_is_ldi = (w_opcode == OP_LDI);
    assign w_we     = w_is_alu | w_is_ldi;
    assign w_wdata  = w_is_ldi ? get_imm(instr) : w_alu_y;

    dp_alu u_alu (
        .op (w_opcode[2:0]),
        .a  (w_rs1_val),
        .b  (w_rs2_val),
        .y  (w_alu_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
        end else begin
            r_pc <= r_pc + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[w_rd] <= w_wdata;
        end
    end

`ifdef DATAPATH_ZFLAG_EN
    logic r_zflag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zflag <= 1'b0;
        end else if (w_we) begin
            r_zflag <= (w_wdata == '0);
        end
    end

    assign zflag = r_zflag;
`endif

    assign pc_out   = r_pc;
    assign debug_r0 = r_regs[0];
    assign debug_r1 = r_regs[1];
    assign debug_r2 = r_regs[2];

endmodule

`default_nettype wire

// File: tb/tb_datapath_core.sv
// ============================================================================
//  Module   : tb_datapath_core
//  Brief    : Self-checking bench for datapath_core against an arithmetic
//             reference model of the instruction set.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_datapath_core;

    logic        clk;
    logic        rst;
    logic [15:0] instr;
    logic [7:0]  pc_out;
    logic [7:0]  debug_r0;
    logic [7:0]  debug_r1;
    logic [7:0]  debug_r2;
`ifdef DATAPATH_ZFLAG_EN
    logic        zflag;
`endif

    int n_total = 0;
    int n_bad   = 0;

    int m_regs [8];
    int m_pc;
    int m_z;

    datapath_core dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .pc_out   (pc_out),
        .debug_r0 (debug_r0),
        .debug_r1 (debug_r1),
`ifdef DATAPATH_ZFLAG_EN
        .debug_r2 (debug_r2),
        .zflag    (zflag)
`else
        .debug_r2 (debug_r2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_alu(input int sel, input int a, input int b);
        int sh;
        sh = b % 8;
        case (sel)
            0: return (a + b) % 256;
            1: return (a - b + 256) % 256;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return 255 - a;
            6: return (a * (1 << sh)) % 256;
            default: return a / (1 << sh);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 0;
        m_pc = 0;
        m_z  = 0;
    endtask

    task automatic check_visible(input string tag);
        check_val({tag, "_pc"}, int'(pc_out), m_pc);
        check_val({tag, "_r0"}, int'(debug_r0), m_regs[0]);
        check_val({tag, "_r1"}, int'(debug_r1), m_regs[1]);
        check_val({tag, "_r2"}, int'(debug_r2), m_regs[2]);
`ifdef DATAPATH_ZFLAG_EN
        check_val({tag, "_z"}, int'(zflag), m_z);
`endif
    endtask

    // Executes one instruction on the DUT and the model, then compares.
    task automatic step(input logic [15:0] ins, input string tag, input bit do_check);
        int op, rd, a, b, res;
        bit we;
        instr = ins;
        op = int'(ins[15:12]);
        rd = int'(ins[11:9]);
        a  = m_regs[int'(ins[8:6])];
        b  = m_regs[int'(ins[5:3])];
        we = 1'b0;
        res = 0;
        if (op < 8) begin
            res = ref_alu(op, a, b);
            we  = 1'b1;
        end else if (op == 15) begin
            res = int'(ins[7:0]);
            we  = 1'b1;
        end
        @(posedge clk);
        #1;
        if (we) begin
            m_regs[rd] = res;
            m_z = (res == 0) ? 1 : 0;
        end
        m_pc = (m_pc + 1) % 256;
        if (do_check) check_visible(tag);
    endtask

    task automatic async_reset_pulse();
        #3 rst = 1'b1;
        model_reset();
        #1;
        check_visible("async_rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] ins;
        rst   = 1'b1;
        instr = 16'h8000;
        model_reset();
        #2;
        check_visible("por");
        @(negedge clk);
        rst = 1'b0;

        // Five cycles of work, then an asynchronous reset between edges.
        for (int i = 0; i < 5; i++) step(16'hF000 | 16'(($urandom_range(0, 2)) << 9) | 16'($urandom_range(1, 255)), "pre", 1'b0);
        instr = 16'hF2AA;
        async_reset_pulse();

        step(16'hF205, "ldi1", 1'b0);
        step(16'hF403, "ldi2", 1'b1);
        check_val("ldi_r1", int'(debug_r1), 8'h05);
        check_val("ldi_r2", int'(debug_r2), 8'h03);
        check_val("ldi_pc", int'(pc_out), 2);
        step(16'h0050, "add", 1'b1);
        check_val("add_r0", int'(debug_r0), 8'h08);
        step(16'h1088, "sub", 1'b1);
        check_val("sub_r0", int'(debug_r0), 8'hFE);
        step(16'h0248, "self", 1'b1);
        check_val("self_r1", int'(debug_r1), 8'h0A);
        step(16'hF281, "ldi3", 1'b0);
        step(16'hF409, "ldi4", 1'b0);
        step(16'h6050, "shl", 1'b1);
        check_val("shl_r0", int'(debug_r0), 8'h02);

        for (int i = 0; i < 400; i++) begin
            ins = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
            step(ins, "rand", 1'b1);
        end

        instr = 16'hF0FF;
        async_reset_pulse();

        // Seed visible registers, then 256 NOPs covering the PC wrap.
        step(16'hF011, "seed0", 1'b0);
        step(16'hF222, "seed1", 1'b0);
        step(16'hF433, "seed2", 1'b0);
        for (int i = 0; i < 256; i++) begin
            step(16'h8000 | 16'(($urandom_range(0, 6)) << 12) | 16'($urandom_range(0, 4095)), "nop", 1'b1);
            if (m_pc == 0) check_val("pc_wrap", int'(pc_out), 0);
        end
        check_val("nop_r0", int'(debug_r0), 8'h11);
        check_val("nop_r1", int'(debug_r1), 8'h22);
        check_val("nop_r2", int'(debug_r2), 8'h33);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
